// File: rtl/sim_run_ctrl_if.sv
// Signal bundle between the simulation harness and the run-control block.
// The slave modport is the run-control side; master is the harness side.
interface sim_run_ctrl_if #(
   parameter int CNT_W   = 32,
   parameter int NUM_RST = 2,
   parameter int CODE_W  = 32
);
   logic               i_pause;
   logic               i_halt;
   logic [CODE_W-1:0]  i_halt_code;
   logic [CNT_W-1:0]   o_counter;
   logic [NUM_RST-1:0] o_rst_out;
   logic               o_run;
   logic               o_done;
   logic               o_timeout;
   logic [CODE_W-1:0]  o_exit_code;

   modport master (
      output i_pause, i_halt, i_halt_code,
      input  o_counter, o_rst_out, o_run, o_done, o_timeout, o_exit_code
   );

   modport slave (
      input  i_pause, i_halt, i_halt_code,
      output o_counter, o_rst_out, o_run, o_done, o_timeout, o_exit_code
   );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run control for the core simulation harness: staggered reset release, cycle
// counter, cycle-budget timeout and halt/exit-code capture with a sticky done.
module sim_run_ctrl #(
   parameter int     CNT_W       = 32,
   parameter longint MAX_CYCLES  = 100000,
   parameter int     NUM_RST     = 2,
   parameter int     RST_HOLD    = 1,
   parameter int     RST_STAGGER = 4,
   parameter int     CODE_W      = 32
) (
   input  logic           clk,
   input  logic           rst,
   sim_run_ctrl_if.slave  bus
);

   localparam logic [31:0]      T_LAST  = 32'(RST_HOLD + (NUM_RST - 1) * RST_STAGGER);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam bit               TMO_EN  = (MAX_CYCLES != 0);

   generate
      if (NUM_RST < 1) begin : g_bad_num_rst
         $error("sim_run_ctrl: NUM_RST must be at least 1");
      end
      if (RST_HOLD < 1) begin : g_bad_rst_hold
         $error("sim_run_ctrl: RST_HOLD must be at least 1");
      end
      if (MAX_CYCLES < 0) begin : g_bad_max_neg
         $error("sim_run_ctrl: MAX_CYCLES must not be negative");
      end
      if (CNT_W < 63 && MAX_CYCLES >= (longint'(1) << CNT_W)) begin : g_bad_max_cycles
         $error("sim_run_ctrl: MAX_CYCLES does not fit in CNT_W bits");
      end
   endgenerate

   typedef enum logic [1:0] {SEQ, RUN, HALTED, TIMEOUT} state_t;

   state_t      state;
   logic [31:0] seq_cnt;
   logic [31:0] seq_nxt;

   assign seq_nxt = seq_cnt + 32'd1;

   // Edge count (after rst falls) on which reset channel k deasserts.
   function automatic logic [31:0] thr(input int k);
      return 32'(RST_HOLD + k * RST_STAGGER);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= SEQ;
         seq_cnt         <= '0;
         bus.o_rst_out   <= '1;
         bus.o_counter   <= CNT_ONE;
         bus.o_run       <= 1'b0;
         bus.o_done      <= 1'b0;
         bus.o_timeout   <= 1'b0;
         bus.o_exit_code <= '0;
      end else begin
         case (state)
            SEQ: begin
               seq_cnt <= seq_nxt;
               for (int k = 0; k < NUM_RST; k++) begin
                  bus.o_rst_out[k] <= (seq_nxt < thr(k));
               end
               if (!bus.i_pause) begin
                  bus.o_counter <= bus.o_counter + CNT_ONE;
               end
               if (seq_nxt == T_LAST) begin
                  state     <= RUN;
                  bus.o_run <= 1'b1;
               end
            end
            RUN: begin
               bus.o_rst_out <= '0;
               // Halt outranks the budget check; neither event advances the counter.
               if (bus.i_halt) begin
                  state           <= HALTED;
                  bus.o_exit_code <= bus.i_halt_code;
                  bus.o_done      <= 1'b1;
                  bus.o_run       <= 1'b0;
               end else if (TMO_EN && bus.o_counter == MAX_CNT) begin
                  state         <= TIMEOUT;
                  bus.o_done    <= 1'b1;
                  bus.o_timeout <= 1'b1;
                  bus.o_run     <= 1'b0;
               end else if (!bus.i_pause) begin
                  bus.o_counter <= bus.o_counter + CNT_ONE;
               end
            end
            default: begin
               bus.o_rst_out <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: four parameterisations exercising reset
// staggering, timeout, halt capture, pause, halt/timeout priority and wrap.
module tb_sim_run_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sim_run_ctrl_if #(.CNT_W(32), .NUM_RST(2), .CODE_W(32)) ia ();
   sim_run_ctrl_if #(.CNT_W(32), .NUM_RST(4), .CODE_W(32)) ib ();
   sim_run_ctrl_if #(.CNT_W(32), .NUM_RST(2), .CODE_W(32)) ic ();
   sim_run_ctrl_if #(.CNT_W(4),  .NUM_RST(2), .CODE_W(32)) id ();

   sim_run_ctrl #(.MAX_CYCLES(200)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
   sim_run_ctrl #(.NUM_RST(4), .RST_HOLD(2), .RST_STAGGER(3), .MAX_CYCLES(20))
      u_b (.clk(clk), .rst(rst), .bus(ib.slave));
   sim_run_ctrl #(.MAX_CYCLES(30)) u_c (.clk(clk), .rst(rst), .bus(ic.slave));
   sim_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) u_d (.clk(clk), .rst(rst), .bus(id.slave));

   int n_cmp = 0;
   int n_err = 0;
   string       sb_tag[$];
   logic [63:0] sb_val[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] v);
      sb_tag.push_back(tag);
      sb_val.push_back(v);
   endtask

   task automatic pop_chk(input logic [63:0] obs);
      if (sb_val.size() == 0) begin
         check("sb_underflow", 64'(sb_val.size()), 64'd1);
      end else begin
         string       t;
         logic [63:0] v;
         t = sb_tag.pop_front();
         v = sb_val.pop_front();
         check(t, obs, v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int edge_n;
   int thr_b [4] = '{2, 5, 8, 11};
   logic [3:0] exp_b;

   initial begin
      ia.i_pause = 0; ia.i_halt = 0; ia.i_halt_code = '0;
      ib.i_pause = 0; ib.i_halt = 0; ib.i_halt_code = '0;
      ic.i_pause = 0; ic.i_halt = 0; ic.i_halt_code = '0;
      id.i_pause = 0; id.i_halt = 0; id.i_halt_code = '0;

      // Defaults (budget shortened to 200): reset state, stagger, timeout.
      rst = 1'b1;
      push("a_rst_rstout", 64'h3); push("a_rst_cnt", 64'd1); push("a_rst_run", 64'd0);
      push("a_rst_done", 64'd0); push("a_rst_tmo", 64'd0); push("a_rst_code", 64'd0);
      tick();
      pop_chk(64'(ia.o_rst_out)); pop_chk(64'(ia.o_counter)); pop_chk(64'(ia.o_run));
      pop_chk(64'(ia.o_done)); pop_chk(64'(ia.o_timeout)); pop_chk(64'(ia.o_exit_code));
      rst = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         push("a_seq_rstout", (e >= 5) ? 64'h0 : 64'h2);
         push("a_seq_run", (e == 5) ? 64'd1 : 64'd0);
         push("a_seq_cnt", 64'(1 + e));
         tick();
         pop_chk(64'(ia.o_rst_out)); pop_chk(64'(ia.o_run)); pop_chk(64'(ia.o_counter));
      end
      edge_n = 5;
      push("a_tmo_edge", 64'd200); push("a_tmo_cnt", 64'd200);
      push("a_tmo_done", 64'd1); push("a_tmo_flag", 64'd1); push("a_tmo_run", 64'd0);
      while (!ia.o_done && edge_n < 400) begin
         tick();
         edge_n++;
      end
      pop_chk(64'(edge_n)); pop_chk(64'(ia.o_counter));
      pop_chk(64'(ia.o_done)); pop_chk(64'(ia.o_timeout)); pop_chk(64'(ia.o_run));
      push("a_tmo_frozen", 64'd200);
      repeat (3) tick();
      pop_chk(64'(ia.o_counter));

      // Defaults: halt at counter 50, later halt ignored.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int n = 0; n < 200 && ia.o_counter != 50; n++) tick();
      check("a_reach50", 64'(ia.o_counter), 64'd50);
      ia.i_halt = 1'b1; ia.i_halt_code = 32'h0000_002A;
      push("a_halt_done", 64'd1); push("a_halt_code", 64'd42);
      push("a_halt_tmo", 64'd0); push("a_halt_cnt", 64'd50); push("a_halt_run", 64'd0);
      tick();
      ia.i_halt = 1'b0;
      pop_chk(64'(ia.o_done)); pop_chk(64'(ia.o_exit_code));
      pop_chk(64'(ia.o_timeout)); pop_chk(64'(ia.o_counter)); pop_chk(64'(ia.o_run));
      ia.i_halt = 1'b1; ia.i_halt_code = 32'd7;
      push("a_rehalt_code", 64'd42); push("a_rehalt_cnt", 64'd50); push("a_rehalt_rstout", 64'd0);
      tick();
      ia.i_halt = 1'b0;
      tick();
      pop_chk(64'(ia.o_exit_code)); pop_chk(64'(ia.o_counter)); pop_chk(64'(ia.o_rst_out));

      // Four channels, hold 2, stagger 3; halt during SEQ ignored; pause in RUN.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         ib.i_halt = (e == 3);
         ib.i_halt_code = 32'd99;
         for (int k = 0; k < 4; k++) exp_b[k] = (e < thr_b[k]);
         push("b_seq_rstout", 64'(exp_b));
         push("b_seq_run", (e == 11) ? 64'd1 : 64'd0);
         tick();
         pop_chk(64'(ib.o_rst_out)); pop_chk(64'(ib.o_run));
      end
      ib.i_halt = 1'b0;
      push("b_seq_halt_done", 64'd0); push("b_seq_halt_code", 64'd0);
      pop_chk(64'(ib.o_done)); pop_chk(64'(ib.o_exit_code));
      push("b_pre_pause_cnt", 64'd13);
      tick();
      pop_chk(64'(ib.o_counter));
      ib.i_pause = 1'b1;
      for (int e = 13; e <= 22; e++) begin
         push("b_pause_cnt", 64'd13);
         tick();
         pop_chk(64'(ib.o_counter));
      end
      ib.i_pause = 1'b0;
      edge_n = 22;
      push("b_tmo_edge", 64'd30); push("b_tmo_cnt", 64'd20);
      push("b_tmo_flag", 64'd1); push("b_tmo_code", 64'd0);
      while (!ib.o_done && edge_n < 100) begin
         tick();
         edge_n++;
      end
      pop_chk(64'(edge_n)); pop_chk(64'(ib.o_counter));
      pop_chk(64'(ib.o_timeout)); pop_chk(64'(ib.o_exit_code));

      // Budget 30: halt presented in the very cycle the budget is hit.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int n = 0; n < 100 && ic.o_counter != 30; n++) tick();
      check("c_reach30", 64'(ic.o_counter), 64'd30);
      ic.i_halt = 1'b1; ic.i_halt_code = 32'hDEAD_BEEF;
      push("c_done", 64'd1); push("c_tmo", 64'd0);
      push("c_code", 64'hDEAD_BEEF); push("c_cnt", 64'd30);
      tick();
      ic.i_halt = 1'b0;
      pop_chk(64'(ic.o_done)); pop_chk(64'(ic.o_timeout));
      pop_chk(64'(ic.o_exit_code)); pop_chk(64'(ic.o_counter));
      push("c_tmo_later", 64'd0);
      repeat (2) tick();
      pop_chk(64'(ic.o_timeout));

      // 4-bit counter, no budget: free wrap, then mid-run reset.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         push("d_cnt", 64'((1 + e) % 16));
         push("d_done", 64'd0);
         tick();
         pop_chk(64'(id.o_counter)); pop_chk(64'(id.o_done));
      end
      rst = 1'b1;
      push("d_mid_rst_cnt", 64'd1); push("d_mid_rst_rstout", 64'h3); push("d_mid_rst_run", 64'd0);
      tick();
      rst = 1'b0;
      pop_chk(64'(id.o_counter)); pop_chk(64'(id.o_rst_out)); pop_chk(64'(id.o_run));
      for (int e = 1; e <= 5; e++) begin
         push("d_reseq_rstout", (e >= 5) ? 64'h0 : 64'h2);
         push("d_reseq_run", (e == 5) ? 64'd1 : 64'd0);
         tick();
         pop_chk(64'(id.o_rst_out)); pop_chk(64'(id.o_run));
      end

      check("sb_drained", 64'(sb_val.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Synthesizable run-control block for the core simulation harness; replaces the ad-hoc counter/reset/finish logic in the bench top.
- Generates a staggered multi-domain reset release, a free-running cycle counter fed to the core's counter input, a cycle-budget timeout, and halt/exit-code capture.
- Raises a sticky done flag; the bench calls $finish on it. The block itself contains no $finish.

Parameters:
- CNT_W, 32: width of the cycle counter.
- MAX_CYCLES, 100000: counter value that triggers timeout. 0 disables timeout.
- NUM_RST, 2: number of downstream reset channels. Minimum 1.
- RST_HOLD, 1: cycles that channel 0 stays in reset after rst deasserts. Minimum 1.
- RST_STAGGER, 4: extra cycles of reset for each higher channel index.
- CODE_W, 32: exit-code width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_pause  in  1  freezes the cycle counter while high.
- i_halt  in  1  core halt request (ebreak/ecall exit). Sampled only in RUN.
- i_halt_code  in  CODE_W  exit code, sampled together with i_halt.
- o_counter  out  CNT_W  cycle counter, drives the core counter input.
- o_rst_out  out  NUM_RST  per-domain active-high resets, registered.
- o_run  out  1  high in RUN.
- o_done  out  1  sticky; high in HALTED or TIMEOUT.
- o_timeout  out  1  sticky; high in TIMEOUT.
- o_exit_code  out  CODE_W  latched halt code.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = SEQ; internal seq_cnt = 0.
  - o_rst_out = all 1s.
  - o_counter = 1.
  - o_run, o_done, o_timeout = 0; o_exit_code = 0.
- rst asserted in any state returns every register to its reset value on that edge. This includes mid-run and after done.
- Per-channel threshold: T_k = RST_HOLD + k*RST_STAGGER.
- SEQ state:
  - seq_cnt increments every edge; i_pause does not affect it.
  - o_rst_out[k] <= (seq_cnt+1 < T_k). Channel 0 therefore drops RST_HOLD edges after rst deasserts.
  - When seq_cnt+1 == T_(NUM_RST-1), state goes to RUN and o_run goes to 1 on that same edge.
  - i_halt is ignored in SEQ.
- Counter:
  - In SEQ and RUN, o_counter increments by 1 each edge unless i_pause = 1, in which case it holds.
  - Wraps modulo 2^CNT_W.
  - Frozen in HALTED and TIMEOUT.
  - It does not increment on the edge that enters HALTED or TIMEOUT, so it holds the value present when the event was detected.
- RUN state, evaluated each edge in priority order:
  1. i_halt = 1: go to HALTED. o_exit_code <= i_halt_code, o_done <= 1, o_run <= 0.
  2. Otherwise, MAX_CYCLES != 0 and o_counter == MAX_CYCLES: go to TIMEOUT. o_done <= 1, o_timeout <= 1, o_run <= 0. The comparison also fires while paused.
  3. Otherwise, stay in RUN.
- Halt and timeout in the same cycle: halt wins and o_timeout stays 0.
- HALTED and TIMEOUT:
  - Terminal until rst.
  - o_rst_out stays 0.
  - Further i_halt pulses are ignored; o_exit_code does not change.
- MAX_CYCLES = 0: no timeout; the counter wraps freely.
- MAX_CYCLES >= 2^CNT_W is a configuration error; flag it with an elaboration-time check.

Test Plan:
1. Defaults, rst high for 1 edge then low, no halt:
   - o_rst_out goes 2'b11 -> 2'b10 after 1 edge, then 2'b00 after 5 edges.
   - o_run rises on the 5th edge.
   - o_done = o_timeout = 1 with o_counter frozen at 100000.
2. Defaults, i_halt = 1 with i_halt_code = 32'h0000_002A for one cycle when o_counter == 50:
   - Next edge: o_done = 1, o_exit_code = 42, o_timeout = 0, o_counter holds 50.
   - A later i_halt with code 7 leaves o_exit_code = 42.
3. NUM_RST = 4, RST_HOLD = 2, RST_STAGGER = 3:
   - Channels deassert at edges 2, 5, 8, 11 after rst falls.
   - o_run rises at edge 11.
   - i_halt pulsed at edge 3 is ignored.
4. MAX_CYCLES = 20, i_pause high for 10 cycles during RUN:
   - o_counter holds during the pause.
   - Timeout occurs 10 edges later than it would unpaused, with o_counter = 20.
5. MAX_CYCLES = 30, i_halt asserted in the cycle where o_counter == 30:
   - Result is HALTED with o_timeout = 0 and o_exit_code = the presented code.
6. CNT_W = 4, MAX_CYCLES = 0:
   - o_counter wraps 15 -> 0 and keeps running; o_done stays 0.
   - rst pulsed mid-run restores o_counter = 1 and o_rst_out = all 1s on that edge, then the reset sequence repeats.
